// File: rtl/pipe_mprf_wb_arb_if.sv
// Write-back arbiter bus: EXU result port, LSU issue/return ports, decode
// hazard query and the merged MPRF write port.
interface pipe_mprf_wb_arb_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AWIDTH = 5
);
  logic              exu_wb_vld_i;
  logic [AWIDTH-1:0] exu_wb_rd_i;
  logic [XLEN-1:0]   exu_wb_data_i;
  logic              exu_wb_stall_o;

  logic              lsu_issue_vld_i;
  logic [AWIDTH-1:0] lsu_issue_rd_i;
  logic              lsu_rdata_vld_i;
  logic [AWIDTH-1:0] lsu_rdata_rd_i;
  logic [XLEN-1:0]   lsu_rdata_i;
  logic              lsu_rdata_rdy_o;

  logic [AWIDTH-1:0] dec_rs1_i;
  logic [AWIDTH-1:0] dec_rs2_i;
  logic [AWIDTH-1:0] dec_rd_i;
  logic              hazard_o;

  logic              exu2mprf_w_req_o;
  logic [AWIDTH-1:0] exu2mprf_rd_addr_o;
  logic [XLEN-1:0]   exu2mprf_rd_data_o;

  modport slave (
    input  exu_wb_vld_i, exu_wb_rd_i, exu_wb_data_i,
    output exu_wb_stall_o,
    input  lsu_issue_vld_i, lsu_issue_rd_i,
    input  lsu_rdata_vld_i, lsu_rdata_rd_i, lsu_rdata_i,
    output lsu_rdata_rdy_o,
    input  dec_rs1_i, dec_rs2_i, dec_rd_i,
    output hazard_o,
    output exu2mprf_w_req_o, exu2mprf_rd_addr_o, exu2mprf_rd_data_o
  );

  modport master (
    output exu_wb_vld_i, exu_wb_rd_i, exu_wb_data_i,
    input  exu_wb_stall_o,
    output lsu_issue_vld_i, lsu_issue_rd_i,
    output lsu_rdata_vld_i, lsu_rdata_rd_i, lsu_rdata_i,
    input  lsu_rdata_rdy_o,
    output dec_rs1_i, dec_rs2_i, dec_rd_i,
    input  hazard_o,
    input  exu2mprf_w_req_o, exu2mprf_rd_addr_o, exu2mprf_rd_data_o
  );
endinterface

// File: rtl/pipe_mprf_wb_arb.sv
// Merges EXU results and queued load returns onto the single MPRF write port,
// with starvation-driven EXU stall and a pending-load scoreboard for decode.
module pipe_mprf_wb_arb #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned AWIDTH     = 5,
  parameter int unsigned LDQ_DEPTH  = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_mprf_wb_arb_if.slave    bus
);

  localparam int unsigned NREG = 1 << AWIDTH;
  localparam int unsigned PW   = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
  localparam int unsigned CW   = $clog2(LDQ_DEPTH + 1);
  localparam int unsigned SW   = $clog2(STARVE_LIM + 1);

  typedef struct packed {
    logic [AWIDTH-1:0] rd;
    logic [XLEN-1:0]   data;
  } ldq_entry_t;

  ldq_entry_t        mem_q [LDQ_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              stall_q, stall_d;
  logic [NREG-1:0]   pend_q, pend_d;

  logic              empty_c, full_c, push_c, pop_c, exu_acc_c;
  ldq_entry_t        head_c, push_ent_c;
  logic              mprf_req_c;
  logic [AWIDTH-1:0] mprf_addr_c;
  logic [XLEN-1:0]   mprf_data_c;

  // Queue status and the arbitration decision for this cycle
  always_comb begin
    empty_c    = (cnt_q == '0);
    full_c     = (cnt_q == CW'(LDQ_DEPTH));
    push_c     = bus.lsu_rdata_vld_i & ~full_c;
    exu_acc_c  = bus.exu_wb_vld_i & ~stall_q;
    pop_c      = ~exu_acc_c & ~empty_c;
    head_c     = mem_q[rd_ptr_q];
    push_ent_c = '{rd: bus.lsu_rdata_rd_i, data: bus.lsu_rdata_i};
  end

  // Next-state for queue pointers, starvation counter, stall and scoreboard
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    stall_d  = 1'b0;
    pend_d   = pend_q;

    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (empty_c || pop_c) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIM)) begin
      starve_d = starve_q + SW'(1);
    end

    // Stall holds until the queue drains an entry; a held stall always pops.
    if (!pop_c && (cnt_d != '0)) begin
      stall_d = stall_q
              | (starve_d == SW'(STARVE_LIM))
              | ((cnt_d == CW'(LDQ_DEPTH)) & exu_acc_c & ~empty_c);
    end

    // Clear before set so a same-cycle reissue of the rd stays pending.
    if (pop_c && (head_c.rd != '0)) pend_d[head_c.rd] = 1'b0;
    if (bus.lsu_issue_vld_i && (bus.lsu_issue_rd_i != '0)) pend_d[bus.lsu_issue_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // MPRF write port: EXU has zero-latency priority, otherwise the queue head
  always_comb begin
    mprf_req_c  = 1'b0;
    mprf_addr_c = '0;
    mprf_data_c = '0;
    if (exu_acc_c) begin
      mprf_req_c  = (bus.exu_wb_rd_i != '0);
      mprf_addr_c = bus.exu_wb_rd_i;
      mprf_data_c = bus.exu_wb_data_i;
    end else if (pop_c) begin
      mprf_req_c  = (head_c.rd != '0);
      mprf_addr_c = head_c.rd;
      mprf_data_c = head_c.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      pend_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      pend_q   <= pend_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= push_ent_c;
  end

  assign bus.exu_wb_stall_o     = stall_q;
  assign bus.lsu_rdata_rdy_o    = ~full_c;
  assign bus.hazard_o           = pend_q[bus.dec_rs1_i] | pend_q[bus.dec_rs2_i] | pend_q[bus.dec_rd_i];
  assign bus.exu2mprf_w_req_o   = mprf_req_c & rst_n;
  assign bus.exu2mprf_rd_addr_o = mprf_addr_c;
  assign bus.exu2mprf_rd_data_o = mprf_data_c;

endmodule
